// File: rtl/seg7_capture.sv
// seg7_capture: reads a multiplexed 7-segment bus back into BCD digits,
// filtering each pattern for stability and assembling complete frames.
module seg7_capture #(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CNT = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dig_err,
   output logic [NUM_DIGITS-1:0]   dig_blank,
   output logic                    cap_vld,
   output logic [2:0]              cap_idx,
   output logic [3:0]              cap_num,
   output logic                    frame_vld
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CNT - 1);
   localparam int SW = 7 + NUM_DIGITS;

   typedef enum logic [1:0] {
      UNSTABLE,
      COUNT,
      HOLD
   } state_t;

   state_t state;
   state_t state_nx;

   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   sel_q;
   logic [6:0]              seg_a;
   logic [NUM_DIGITS-1:0]   sel_a;
   logic [SW-1:0]           prev;
   logic                    diff;
   logic                    onehot;
   logic                    cap;
   logic [CW-1:0]           cnt;
   logic [2:0]              enc;
   logic [3:0]              d_num;
   logic                    d_err;
   logic                    d_blank;
   logic [4*NUM_DIGITS-1:0] sh_num;
   logic [NUM_DIGITS-1:0]   sh_err;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic [NUM_DIGITS-1:0]   seen;
   logic [NUM_DIGITS-1:0]   seen_nx;
   logic                    frame_pend;

   assign seg_a   = ACTIVE_LOW ? ~seg_q : seg_q;
   assign sel_a   = ACTIVE_LOW ? ~sel_q : sel_q;
   assign diff    = {seg_a, sel_a} != prev;
   assign onehot  = $countones(sel_a) == 1;
   assign seen_nx = seen | sel_a;

   // prev holds the previous active-high sample for the settle compare
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '0;
         sel_q <= '0;
         prev  <= '0;
      end else begin
         seg_q <= seg;
         sel_q <= dig_sel;
         prev  <= {seg_a, sel_a};
      end
   end

   always_comb begin
      d_num   = 4'hF;
      d_err   = 1'b0;
      d_blank = 1'b0;
      case (seg_a)
         7'h7E:   d_num = 4'd0;
         7'h30:   d_num = 4'd1;
         7'h6D:   d_num = 4'd2;
         7'h79:   d_num = 4'd3;
         7'h33:   d_num = 4'd4;
         7'h5B:   d_num = 4'd5;
         7'h5F:   d_num = 4'd6;
         7'h70:   d_num = 4'd7;
         7'h7F:   d_num = 4'd8;
         7'h7B:   d_num = 4'd9;
         7'h00:   d_blank = 1'b1;
         default: d_err = 1'b1;
      endcase
   end

   always_comb begin
      enc = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_a[i]) enc = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= UNSTABLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      unique case (state)
         UNSTABLE: begin
            state_nx = diff ? UNSTABLE : COUNT;
         end
         COUNT: begin
            if (diff) begin
               state_nx = UNSTABLE;
            end else if (cnt == CNT_CAP && onehot) begin
               cap      = 1'b1;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (diff) state_nx = UNSTABLE;
         end
         default: state_nx = UNSTABLE;
      endcase
   end

   // counts unchanged compares; saturates so long dwells never wrap
   always_ff @(posedge clk) begin
      if (rst)                 cnt <= '0;
      else if (diff)           cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_vld <= 1'b0;
         cap_idx <= 3'd0;
         cap_num <= 4'd0;
      end else begin
         cap_vld <= cap;
         if (cap) begin
            cap_idx <= enc;
            cap_num <= d_num;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_num   <= '0;
         sh_err   <= '0;
         sh_blank <= '0;
      end else if (cap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_a[i]) begin
               sh_num[4*i +: 4] <= d_num;
               sh_err[i]        <= d_err;
               sh_blank[i]      <= d_blank;
            end
         end
      end
   end

   // frame publish lags the completing capture by one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         seen       <= '0;
         frame_pend <= 1'b0;
         frame_vld  <= 1'b0;
         digits     <= '1;
         dig_err    <= '0;
         dig_blank  <= '0;
      end else begin
         frame_pend <= cap && (&seen_nx);
         frame_vld  <= frame_pend;
         if (frame_pend) begin
            digits    <= sh_num;
            dig_err   <= sh_err;
            dig_blank <= sh_blank;
            seen      <= '0;
         end else if (cap) begin
            seen <= seen_nx;
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: active-high and active-low instances share one
// stimulus stream and are checked against a run-length reference model.
module tb_seg7_capture;

   localparam int N = 4;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_b;
   logic [3:0] sel_b;

   logic [15:0] dig_h, dig_l;
   logic [3:0]  err_h, err_l, blk_h, blk_l;
   logic        cap_h, cap_l, frm_h, frm_l;
   logic [2:0]  idx_h, idx_l;
   logic [3:0]  num_h, num_l;

   always #5 clk = ~clk;

   seg7_capture #(
      .NUM_DIGITS(N), .STABLE_CNT(S), .ACTIVE_LOW(1'b0)
   ) u_h (
      .clk(clk), .rst(rst), .seg(seg_b), .dig_sel(sel_b),
      .digits(dig_h), .dig_err(err_h), .dig_blank(blk_h),
      .cap_vld(cap_h), .cap_idx(idx_h), .cap_num(num_h),
      .frame_vld(frm_h)
   );

   seg7_capture #(
      .NUM_DIGITS(N), .STABLE_CNT(S), .ACTIVE_LOW(1'b1)
   ) u_l (
      .clk(clk), .rst(rst), .seg(~seg_b), .dig_sel(~sel_b),
      .digits(dig_l), .dig_err(err_l), .dig_blank(blk_l),
      .cap_vld(cap_l), .cap_idx(idx_l), .cap_num(num_l),
      .frame_vld(frm_l)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   // {blank, err, num}
   function automatic logic [5:0] ref_dec(input logic [6:0] p);
      for (int i = 0; i < 10; i++)
         if (p == pat[i]) return {2'b00, 4'(i)};
      if (p == 7'h00) return {2'b10, 4'hF};
      return {2'b01, 4'hF};
   endfunction

   int          cyc = 0;
   int          run = 0;
   logic [10:0] last;
   bit          last_ok;
   bit          cap_nxt, frm_nxt;
   int          nxt_idx;
   logic [5:0]  nxt_dec;
   logic [3:0]  sh_n [N];
   bit          sh_e [N], sh_b [N], seen [N];
   bit          e_cap, e_frm;
   int          e_idx;
   logic [3:0]  e_num;
   logic [15:0] e_dig;
   logic [3:0]  e_err, e_blk;

   int ncap_h, ncap_l, nfrm_h, last_cap_cyc;
   int o_lidx, o_lnum;

   task automatic model_edge();
      bit all;
      cyc++;
      if (rst) begin
         run = 0; last_ok = 0; cap_nxt = 0; frm_nxt = 0;
         e_cap = 0; e_frm = 0; e_idx = 0; e_num = 0;
         e_dig = 16'hFFFF; e_err = 0; e_blk = 0;
         for (int i = 0; i < N; i++) begin
            sh_n[i] = 0; sh_e[i] = 0; sh_b[i] = 0; seen[i] = 0;
         end
      end else begin
         e_cap = cap_nxt;
         e_frm = frm_nxt;
         if (cap_nxt) begin
            e_idx = nxt_idx;
            e_num = nxt_dec[3:0];
         end
         if (frm_nxt) begin
            for (int i = 0; i < N; i++) begin
               e_dig[4*i +: 4] = sh_n[i];
               e_err[i] = sh_e[i];
               e_blk[i] = sh_b[i];
               seen[i] = 0;
            end
         end
         frm_nxt = 0;
         if (cap_nxt) begin
            sh_n[nxt_idx] = nxt_dec[3:0];
            sh_e[nxt_idx] = nxt_dec[4];
            sh_b[nxt_idx] = nxt_dec[5];
            seen[nxt_idx] = 1;
            all = 1;
            for (int i = 0; i < N; i++) if (!seen[i]) all = 0;
            frm_nxt = all;
         end
         cap_nxt = 0;
         if (last_ok && {seg_b, sel_b} == last) run++;
         else run = 1;
         last = {seg_b, sel_b};
         last_ok = 1;
         // a dwell yields its capture once S+1 identical samples are in
         if (run == S + 1 && $countones(sel_b) == 1) begin
            cap_nxt = 1;
            for (int i = 0; i < N; i++) if (sel_b[i]) nxt_idx = i;
            nxt_dec = ref_dec(seg_b);
         end
      end
   endtask

   task automatic check_outs();
      chk("cap_h", 32'(cap_h), 32'(e_cap));
      chk("cap_l", 32'(cap_l), 32'(e_cap));
      if (e_cap) begin
         chk("idx_h", 32'(idx_h), 32'(e_idx));
         chk("num_h", 32'(num_h), 32'(e_num));
         chk("idx_l", 32'(idx_l), 32'(e_idx));
         chk("num_l", 32'(num_l), 32'(e_num));
      end
      chk("frm_h", 32'(frm_h), 32'(e_frm));
      chk("frm_l", 32'(frm_l), 32'(e_frm));
      chk("dig_h", 32'(dig_h), 32'(e_dig));
      chk("dig_l", 32'(dig_l), 32'(e_dig));
      chk("err_h", 32'(err_h), 32'(e_err));
      chk("blk_l", 32'(blk_l), 32'(e_blk));
      if (cap_h) begin
         ncap_h++;
         last_cap_cyc = cyc;
      end
      if (cap_l) begin
         ncap_l++;
         o_lidx = 32'(idx_l);
         o_lnum = 32'(num_l);
      end
      if (frm_h) nfrm_h++;
   endtask

   task automatic step(input logic [6:0] s, input logic [3:0] d,
                       input logic r);
      @(negedge clk);
      check_outs();
      seg_b = s;
      sel_b = d;
      rst   = r;
      @(posedge clk);
      model_edge();
   endtask

   task automatic hold(input logic [6:0] s, input logic [3:0] d,
                       input int n);
      repeat (n) step(s, d, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      rst = 1'b1; seg_b = '0; sel_b = '0;
      ncap_h = 0; ncap_l = 0; nfrm_h = 0; last_cap_cyc = 0;
      o_lidx = -1; o_lnum = -1;
      @(posedge clk);
      model_edge();
      step(7'h00, 4'h0, 1'b1);

      hold(7'h30, 4'b0001, 8);
      hold(7'h6D, 4'b0010, 8);
      hold(7'h79, 4'b0100, 8);
      hold(7'h33, 4'b1000, 8);
      #1;
      chk("t1_digits", 32'(dig_h), 32'h4321);
      chk("t1_err", 32'(err_h | blk_h), 32'h0);
      chk("t1_ncap", 32'(ncap_h), 32'd4);
      chk("t1_nfrm", 32'(nfrm_h), 32'd1);

      ncap_h = 0;
      hold(7'h7F, 4'b0001, 3);
      step(7'h7E, 4'b0001, 1'b0);
      t0 = cyc;
      hold(7'h7E, 4'b0001, 7);
      #1;
      chk("t2_ncap", 32'(ncap_h), 32'd1);
      chk("t2_lat", 32'(last_cap_cyc - t0), 32'd5);

      hold(7'h30, 4'b0001, 8);
      hold(7'h6D, 4'b0010, 8);
      hold(7'h01, 4'b0100, 8);
      hold(7'h00, 4'b1000, 8);
      #1;
      chk("t3_err", 32'(err_h), 32'b0100);
      chk("t3_blank", 32'(blk_h), 32'b1000);
      chk("t3_hi", 32'(dig_h[15:8]), 32'hFF);

      ncap_h = 0; ncap_l = 0; nfrm_h = 0;
      hold(7'h7E, 4'b0000, 20);
      hold(7'h7E, 4'b0011, 20);
      #1;
      chk("t4_ncap_h", 32'(ncap_h), 32'd0);
      chk("t4_ncap_l", 32'(ncap_l), 32'd0);
      chk("t4_nfrm", 32'(nfrm_h), 32'd0);

      ncap_l = 0;
      hold(7'h7B, 4'b0001, 100);
      #1;
      chk("t5_ncap_l", 32'(ncap_l), 32'd1);
      chk("t5_idx", 32'(o_lidx), 32'd0);
      chk("t5_num", 32'(o_lnum), 32'd9);

      hold(7'h30, 4'b0001, 8);
      hold(7'h6D, 4'b0010, 8);
      step(7'h00, 4'h0, 1'b1);
      nfrm_h = 0;
      hold(7'h70, 4'b0100, 8);
      hold(7'h7F, 4'b1000, 8);
      hold(7'h5B, 4'b0001, 8);
      hold(7'h5F, 4'b0010, 8);
      #1;
      chk("t6_nfrm", 32'(nfrm_h), 32'd1);
      chk("t6_dig_h", 32'(dig_h), 32'h8765);
      chk("t6_dig_l", 32'(dig_l), 32'h8765);

      for (int k = 0; k < 300; k++) begin
         int n;
         int r;
         logic [3:0] d;
         logic [6:0] s;
         n = $urandom_range(1, 12);
         r = $urandom_range(0, 99);
         if (r < 75) d = 4'(1 << $urandom_range(0, 3));
         else        d = 4'($urandom);
         r = $urandom_range(0, 99);
         if (r < 70)      s = pat[$urandom_range(0, 9)];
         else if (r < 80) s = 7'h00;
         else             s = 7'($urandom);
         if ($urandom_range(0, 49) == 0) step(s, d, 1'b1);
         hold(s, d, n);
      end
      hold(7'h00, 4'h0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Decodes the multiplexed 7-segment display bus back into BCD digits. This is the inverse of the BCD-to-7-segment driver.
- Watches the segment lines and the one-hot digit-select strobe, waits for each pattern to settle, decodes it and stores it per digit.
- Pulses a frame-complete strobe once every digit position has been refreshed.
- Used for display self-check and readback of the alarm clock display.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8).
- STABLE_CNT, 16, consecutive identical samples required before capture (>=2).
- ACTIVE_LOW, 1, 1 = segment and digit-select lines are active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- seg  input  7  segment lines; seg[6]=A, seg[5]=B, ... seg[0]=G.
- dig_sel  input  NUM_DIGITS  digit-select strobe; exactly one bit active for a valid selection.
- digits  output  4*NUM_DIGITS  last completed frame; digit i at bits [4i+3:4i].
- dig_err  output  NUM_DIGITS  per-digit flag: undecodable pattern in the last frame.
- dig_blank  output  NUM_DIGITS  per-digit flag: all segments off in the last frame.
- cap_vld  output  1  one-cycle pulse: a digit was captured.
- cap_idx  output  3  index of the captured digit; valid with cap_vld.
- cap_num  output  4  decoded value of the captured digit; valid with cap_vld.
- frame_vld  output  1  one-cycle pulse: digits, dig_err and dig_blank were just updated.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Input stage:
  - seg and dig_sel are registered once, then inverted internally when ACTIVE_LOW=1.
  - All further logic sees active-high values.
- Decode, with pattern written as ABCDEFG (hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - 00 decodes to blank: num=F, blank=1, err=0.
  - Any other pattern decodes to num=F, err=1, blank=0.
- Stability FSM, three states:
  - UNSTABLE: sampled {seg,dig_sel} differs from the previous sample. Clear the counter, go to COUNT.
  - COUNT:
    - Increment the counter while the sample is unchanged.
    - If the sample changes, go to UNSTABLE.
    - When the sample has been identical for STABLE_CNT consecutive samples and dig_sel is one-hot, capture and go to HOLD.
  - HOLD: no further captures. If the sample changes, go to UNSTABLE.
- Capture rules:
  - Exactly one capture per stable dwell.
  - dig_sel all-zero or multi-hot never captures; the FSM stays in COUNT or HOLD without capturing.
  - A one-hot bit at an index >= NUM_DIGITS is impossible by width.
- Latency: cap_vld is high in the cycle exactly STABLE_CNT+1 clocks after the first edge that samples the new stable value.
- Capture action:
  - cap_vld=1; cap_idx and cap_num carry the decoded result.
  - The per-digit shadow register for that index takes num, err and blank.
  - seen[idx] is set.
- Frame:
  - When a capture makes seen all-ones, the shadow registers copy to digits, dig_err and dig_blank on the next edge.
  - frame_vld pulses for that one cycle, 1 cycle after the completing cap_vld.
  - seen clears on that same edge.
  - Recaptures of an already-seen index overwrite its shadow value; the latest value wins. They do not advance the frame.
- Reset:
  - All outputs reset to 0, except digits, which reset to all F.
  - Counter, seen and shadow registers clear; the FSM goes to UNSTABLE.
  - Reset mid-dwell or mid-frame discards partial progress.
- Counter width: clog2(STABLE_CNT+1). The counter saturates and never wraps.
- Outputs are driven from registers only; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset and one frame:
   - Stimulus: assert rst for 2 cycles; then with NUM_DIGITS=4, STABLE_CNT=4, ACTIVE_LOW=0, drive dig_sel=0001/seg=30, 0010/seg=6D, 0100/seg=79, 1000/seg=33, each held 8 cycles.
   - Required: during reset digits=FFFF and all flags 0. After the frame, four cap_vld pulses with idx 0..3 and num 1,2,3,4; then one frame_vld; digits=16'h4321, dig_err=0, dig_blank=0.
2. Glitch rejection:
   - Stimulus: hold dig_sel=0001/seg=7F for 3 cycles, change seg to 7E, hold 6 cycles.
   - Required: no capture for 7F. One capture of num=0, with cap_vld exactly 5 cycles after the 7E sample.
3. Error and blank:
   - Stimulus: seg=01 on digit 2 and seg=00 on digit 3 within a full frame.
   - Required: dig_err=0100, dig_blank=1000, digits[11:8]=F, digits[15:12]=F.
4. Invalid select:
   - Stimulus: dig_sel=0000, then 0011, each stable for 20 cycles.
   - Required: no cap_vld, seen unchanged, no frame_vld.
5. Active-low and long dwell:
   - Stimulus: ACTIVE_LOW=1; dig_sel=1110 with seg=~7B, held 100 cycles.
   - Required: exactly one cap_vld, with idx=0 and num=9.
6. Mid-frame reset:
   - Stimulus: capture digits 0 and 1, pulse rst, then send a full frame of 5,6,7,8.
   - Required: frame_vld only after all four new captures; digits=16'h8765.
